// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master: per-transfer CPOL/CPHA, bit order and
// target select; one frame of DATA_W bits per start/done handshake.
module spi_master_param #(
  parameter int DATA_W   = 8,
  parameter int CLK_DIV  = 4,
  parameter int NUM_CS   = 2,
  parameter int CS_IDX_W = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [DATA_W-1:0]   tx_data,
  input  logic [CS_IDX_W-1:0] cs_sel,
  input  logic                cpol,
  input  logic                cpha,
  input  logic                lsb_first,
  input  logic                miso,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   rx_data,
  output logic                sclk,
  output logic                mosi,
  output logic [NUM_CS-1:0]   cs_n
);
  // state | meaning
  // IDLE  | waiting for start, sclk parked at last cpol
  // LEAD  | cs asserted, setup half-period before first edge
  // XFER  | 2*DATA_W sclk toggles, shifting and sampling
  // TRAIL | cs held, sclk at cpol, hold half-period
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TGL_W = $clog2(2 * DATA_W + 1);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [TGL_W-1:0] TGL_LOAD = TGL_W'(2 * DATA_W);

  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

  state_t              state, state_next;
  logic [DIV_W-1:0]    div_cnt;
  logic [TGL_W-1:0]    tgl_left;
  logic [DATA_W-1:0]   tx_sh, rx_sh;
  logic                cpha_q, lsb_q;
  logic                tc, accept, tgl, leading, last_tgl, emit, sample, finish;
  logic [NUM_CS-1:0]   cs_dec_n;

  function automatic logic head(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? {1'b0, v[DATA_W-1:1]} : {v[DATA_W-2:0], 1'b0};
  endfunction

  always_comb begin
    state_next = state;
    tc         = (div_cnt == '0);
    accept     = 1'b0;
    tgl        = 1'b0;
    leading    = 1'b0;
    last_tgl   = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE:  if (start) begin
               accept     = 1'b1;
               state_next = LEAD;
             end
      LEAD:  if (tc) state_next = XFER;
      XFER:  if (tc) begin
               tgl      = 1'b1;
               leading  = ~tgl_left[0];
               last_tgl = (tgl_left == TGL_W'(1));
               if (last_tgl) state_next = TRAIL;
             end
      TRAIL: if (tc) begin
               finish     = 1'b1;
               state_next = IDLE;
             end
      default: state_next = IDLE;
    endcase
    // CPHA=0 samples on leading edges, CPHA=1 on trailing edges
    sample = tgl & (leading ^ cpha_q);
    emit   = tgl & (cpha_q ? leading : (~leading & ~last_tgl));
    for (int i = 0; i < NUM_CS; i++) cs_dec_n[i] = (cs_sel != CS_IDX_W'(i));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      div_cnt  <= '0;
      tgl_left <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= '1;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      done  <= finish;
      if (accept || (state != IDLE && tc)) div_cnt <= DIV_LOAD;
      else if (state != IDLE)              div_cnt <= div_cnt - DIV_W'(1);
      if (state == LEAD && tc) tgl_left <= TGL_LOAD;
      else if (tgl)            tgl_left <= tgl_left - TGL_W'(1);
      if (accept) begin
        cpha_q <= cpha;
        lsb_q  <= lsb_first;
        sclk   <= cpol;
        cs_n   <= cs_dec_n;
        rx_sh  <= '0;
        // CPHA=0 must present the first bit before the first leading edge
        if (!cpha) begin
          mosi  <= head(tx_data, lsb_first);
          tx_sh <= shift_out(tx_data, lsb_first);
        end else begin
          mosi  <= 1'b0;
          tx_sh <= tx_data;
        end
      end else begin
        if (tgl) sclk <= ~sclk;
        if (emit) begin
          mosi  <= head(tx_sh, lsb_q);
          tx_sh <= shift_out(tx_sh, lsb_q);
        end
        if (sample) rx_sh <= lsb_q ? {miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], miso};
        if (finish) begin
          cs_n    <= '1;
          mosi    <= 1'b0;
          rx_data <= rx_sh;
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: mode/bit-order frames against an
// edge-driven slave model, start-while-busy, mid-transfer reset, back-to-back.
module tb_spi_master_param;
  logic       clk = 1'b0;
  logic       reset_n, start, cpol, cpha, lsb_first, miso;
  logic [7:0] tx_data;
  logic [0:0] cs_sel;
  logic       busy, done, sclk, mosi;
  logic [7:0] rx_data;
  logic [1:0] cs_n;

  int checks = 0, failures = 0;

  spi_master_param #(.DATA_W(8), .CLK_DIV(2), .NUM_CS(2), .CS_IDX_W(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .tx_data(tx_data), .cs_sel(cs_sel),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .miso(miso), .busy(busy),
    .done(done), .rx_data(rx_data), .sclk(sclk), .mosi(mosi), .cs_n(cs_n)
  );

  always #5 clk = ~clk;

  // slave model: changes miso only on the edge opposite the master's sampling edge
  logic       loop = 1'b0, miso_s = 1'b0, s_active = 1'b0;
  logic       s_cpol = 1'b0, s_cpha = 1'b0, s_lsb = 1'b0, s_ld_seen = 1'b0;
  logic [7:0] s_frame = '0, s_mosi = '0;
  int         s_idx = 0, s_tgl = 0, done_cnt = 0, cs_bad = 0;
  logic [1:0] exp_cs = 2'b11;

  assign miso = loop ? mosi : miso_s;

  function automatic logic sbit(input int i);
    if (i > 7) return 1'b0;
    return s_lsb ? s_frame[i] : s_frame[7-i];
  endfunction

  always @(sclk) begin
    if (s_active) begin
      if (sclk !== s_cpol) begin
        s_ld_seen = 1'b1;
        s_tgl++;
        if (!s_cpha) s_mosi = {s_mosi[6:0], mosi};
        else begin
          miso_s = sbit(s_idx);
          s_idx++;
        end
      end else if (s_ld_seen) begin
        s_tgl++;
        if (!s_cpha) begin
          s_idx++;
          miso_s = sbit(s_idx);
        end else s_mosi = {s_mosi[6:0], mosi};
      end
    end
  end

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1 && cs_n !== exp_cs) cs_bad++;
  end

  task automatic setup(input logic [7:0] tx, input logic pol, pha, lsb, input logic [0:0] cs,
                       input logic [7:0] frame, input logic lp);
    tx_data = tx; cpol = pol; cpha = pha; lsb_first = lsb; cs_sel = cs; loop = lp;
    s_cpol = pol; s_cpha = pha; s_lsb = lsb; s_frame = frame;
    s_idx = 0; s_ld_seen = 1'b0; s_tgl = 0; s_mosi = '0; s_active = 1'b1;
    miso_s = pha ? 1'b0 : sbit(0);
    exp_cs = (cs == 1'b0) ? 2'b10 : 2'b01;
    done_cnt = 0; cs_bad = 0;
  endtask

  task automatic launch(input logic [7:0] tx, input logic pol, pha, lsb, input logic [0:0] cs,
                        input logic [7:0] frame, input logic lp);
    @(negedge clk);
    setup(tx, pol, pha, lsb, cs, frame, lp);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // returns at the negedge inside the done cycle; nb counts busy cycles seen
  task automatic wait_done(output logic to, output int nb);
    to = 1'b1;
    nb = (busy === 1'b1) ? 1 : 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        to = 1'b0;
        break;
      end
      if (busy === 1'b1) nb++;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx got=%h exp=00", rx_data); end
    checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL reset_sclk got=%b exp=0", sclk); end
    checks++; if (mosi !== 1'b0) begin failures++; $display("FAIL reset_mosi got=%b exp=0", mosi); end
    checks++; if (cs_n !== 2'b11) begin failures++; $display("FAIL reset_cs got=%b exp=11", cs_n); end
    reset_n = 1'b1;
  endtask

  task automatic test_mode0;
    logic to; int nb;
    launch(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    checks++; if (mosi !== 1'b1) begin failures++; $display("FAIL m0_first_bit got=%b exp=1", mosi); end
    wait_done(to, nb);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL m0_timeout got=%b exp=0", to); end
    checks++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL m0_rx got=%h exp=a5", rx_data); end
    checks++; if (s_mosi !== 8'hA5) begin failures++; $display("FAIL m0_mosi_seq got=%h exp=a5", s_mosi); end
    checks++; if (s_tgl !== 16) begin failures++; $display("FAIL m0_toggles got=%0d exp=16", s_tgl); end
    checks++; if (nb !== 36) begin failures++; $display("FAIL m0_busy_len got=%0d exp=36", nb); end
    checks++; if (cs_n !== 2'b11 || busy !== 1'b0) begin failures++; $display("FAIL m0_done_cycle cs=%b busy=%b exp cs=11 busy=0", cs_n, busy); end
    checks++; if (cs_bad !== 0) begin failures++; $display("FAIL m0_cs_busy got=%0d bad cycles exp=0", cs_bad); end
    repeat (3) @(negedge clk);
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL m0_done_count got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_mode3;
    logic to; int nb;
    launch(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 8'hC3, 1'b0);
    checks++; if (sclk !== 1'b1) begin failures++; $display("FAIL m3_sclk_lead got=%b exp=1", sclk); end
    wait_done(to, nb);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL m3_timeout got=%b exp=0", to); end
    checks++; if (rx_data !== 8'hC3) begin failures++; $display("FAIL m3_rx got=%h exp=c3", rx_data); end
    checks++; if (s_mosi !== 8'h3C) begin failures++; $display("FAIL m3_mosi_seq got=%h exp=3c", s_mosi); end
    checks++; if (sclk !== 1'b1) begin failures++; $display("FAIL m3_sclk_idle got=%b exp=1", sclk); end
    checks++; if (s_tgl !== 16) begin failures++; $display("FAIL m3_toggles got=%0d exp=16", s_tgl); end
  endtask

  task automatic test_mode12;
    logic to; int nb;
    launch(8'h81, 1'b0, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0);
    checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL m1_sclk_lead got=%b exp=0", sclk); end
    wait_done(to, nb);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL m1_timeout got=%b exp=0", to); end
    checks++; if (rx_data !== 8'h5A) begin failures++; $display("FAIL m1_rx got=%h exp=5a", rx_data); end
    checks++; if (s_mosi !== 8'h81) begin failures++; $display("FAIL m1_mosi_seq got=%h exp=81", s_mosi); end
    checks++; if (cs_bad !== 0) begin failures++; $display("FAIL m1_cs_busy got=%0d bad cycles exp=0", cs_bad); end
    launch(8'h81, 1'b1, 1'b0, 1'b0, 1'b1, 8'h96, 1'b0);
    checks++; if (cs_n !== 2'b01) begin failures++; $display("FAIL m2_cs got=%b exp=01", cs_n); end
    wait_done(to, nb);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL m2_timeout got=%b exp=0", to); end
    checks++; if (rx_data !== 8'h96) begin failures++; $display("FAIL m2_rx got=%h exp=96", rx_data); end
    checks++; if (s_mosi !== 8'h81) begin failures++; $display("FAIL m2_mosi_seq got=%h exp=81", s_mosi); end
    checks++; if (nb !== 36) begin failures++; $display("FAIL m2_busy_len got=%0d exp=36", nb); end
  endtask

  task automatic test_start_ignore;
    logic to; int nb;
    launch(8'h5C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    repeat (4) @(negedge clk);
    tx_data = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(to, nb);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL ign_timeout got=%b exp=0", to); end
    checks++; if (rx_data !== 8'h5C) begin failures++; $display("FAIL ign_rx got=%h exp=5c", rx_data); end
    checks++; if (s_mosi !== 8'h5C) begin failures++; $display("FAIL ign_mosi_seq got=%h exp=5c", s_mosi); end
    repeat (4) @(negedge clk);
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL ign_done_count got=%0d exp=1", done_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ign_idle got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid;
    logic to; int nb;
    launch(8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s_tgl >= 7) begin
        to = 1'b0;
        break;
      end
    end
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL rst_mid_reach got=%0d toggles exp=7", s_tgl); end
    s_active = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++; if (cs_n !== 2'b11) begin failures++; $display("FAIL rst_mid_cs got=%b exp=11", cs_n); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL rst_mid_sclk got=%b exp=0", sclk); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL rst_mid_rx got=%h exp=00", rx_data); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (done_cnt !== 0) begin failures++; $display("FAIL rst_mid_done got=%0d exp=0", done_cnt); end
    launch(8'h3A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    wait_done(to, nb);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL rst_next_timeout got=%b exp=0", to); end
    checks++; if (rx_data !== 8'h3A) begin failures++; $display("FAIL rst_next_rx got=%h exp=3a", rx_data); end
  endtask

  task automatic test_back_to_back;
    logic to; int nb;
    @(negedge clk);
    setup(8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    start = 1'b1;
    @(negedge clk);
    wait_done(to, nb);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL b2b_first_timeout got=%b exp=0", to); end
    checks++; if (rx_data !== 8'h12) begin failures++; $display("FAIL b2b_first_rx got=%h exp=12", rx_data); end
    checks++; if (cs_n !== 2'b11) begin failures++; $display("FAIL b2b_gap_cs got=%b exp=11", cs_n); end
    setup(8'h34, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1 || cs_n !== 2'b10) begin failures++; $display("FAIL b2b_restart busy=%b cs=%b exp busy=1 cs=10", busy, cs_n); end
    wait_done(to, nb);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL b2b_second_timeout got=%b exp=0", to); end
    checks++; if (rx_data !== 8'h34) begin failures++; $display("FAIL b2b_second_rx got=%h exp=34", rx_data); end
    checks++; if (nb !== 36) begin failures++; $display("FAIL b2b_busy_len got=%0d exp=36", nb); end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; tx_data = '0; cs_sel = '0;
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    test_reset;
    test_mode0;
    test_mode3;
    test_mode12;
    test_start_ignore;
    test_reset_mid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
